// File: rtl/mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_if
// Brief    : Operand/product valid-ready bundle for the sequential multiplier.
// Revision : 1.0  initial release
// ============================================================================
interface mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     ina;
    logic [WIDTH-1:0]     inb;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out;

    modport master (
        output in_valid, ina, inb, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, ina, inb, out_ready,
        output in_ready, out_valid, out
    );
endinterface
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq
// Brief    : Shift-add multiplier, one partial product per cycle, optional
//            two's-complement operands via sign/magnitude.
// Revision : 1.0  initial release
// ============================================================================
module mult_seq #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  wire logic   clk,
    input  wire logic   aclr,
    mult_seq_if.slave   bus
);
    localparam int                  c_cw    = $clog2(WIDTH);
    localparam logic [c_cw-1:0]     c_last  = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0]     c_cnt1  = c_cw'(1);
    localparam logic [WIDTH-1:0]    c_one   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]  c_one2  = (2*WIDTH)'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [c_cw-1:0]    r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_out;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;

    // Signed mode multiplies magnitudes; -2^(WIDTH-1) still fits as unsigned.
    generate
        if (SIGNED != 0) begin : g_signed
            assign w_mag_a = bus.ina[WIDTH-1] ? (~bus.ina + c_one) : bus.ina;
            assign w_mag_b = bus.inb[WIDTH-1] ? (~bus.inb + c_one) : bus.inb;
            assign w_neg   = bus.ina[WIDTH-1] ^ bus.inb[WIDTH-1];
        end else begin : g_unsigned
            assign w_mag_a = bus.ina;
            assign w_mag_b = bus.inb;
            assign w_neg   = 1'b0;
        end
    endgenerate

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;
    // Negating a zero accumulator yields zero, so no negative-zero case exists.
    assign w_prod     = r_neg ? (~w_acc_next + c_one2) : w_acc_next;

    assign bus.in_ready  = (r_state == c_idle) & ~aclr;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state     <= c_idle;
            r_count     <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= w_neg;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= c_busy;
                    end
                end
                c_busy: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + c_cnt1;
                    if (r_count == c_last) begin
                        r_out       <= w_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= c_done;
                    end
                end
                c_done: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential shift-add multiplier: the successor to the fixed 8x8→16 combinational multiply. It adds selectable operand width, an optional two's-complement mode, and valid/ready handshakes on both sides, trading throughput for area. It sits on datapath paths where one product per WIDTH+2 cycles is enough and a full-array multiplier is too large.

## Interface
- WIDTH, 8, operand width in bits (≥2); the product is 2*WIDTH bits.
- SIGNED, 0, 0 = unsigned operands and product; 1 = two's-complement operands and product.
- clk  input  1  sole clock; all state updates on the rising edge.
- aclr  input  1  reset, asynchronous, active-high; clears all state immediately.
- in_valid  input  1  operand pair on ina/inb is valid.
- in_ready  output  1  block can accept operands; equals (state==IDLE) & ~aclr.
- ina  input  WIDTH  multiplicand.
- inb  input  WIDTH  multiplier.
- out_valid  output  1  product on out is valid (registered).
- out_ready  input  1  consumer accepts the product.
- out  output  2*WIDTH  product (registered).

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE, with out=0, out_valid=0, and the iteration counter, accumulator and operand registers at 0.
- IDLE: when in_valid & in_ready at an edge (the accept):
  - capture the operands; SIGNED=1 stores |ina|, |inb| as WIDTH-bit unsigned magnitudes plus a flag neg = ina[MSB]^inb[MSB]; SIGNED=0 sets neg=0;
  - clear the accumulator, load count=0, go to BUSY.
- BUSY: one iteration per cycle. If the multiplier LSB is 1, add the shifted multiplicand to the 2*WIDTH-bit accumulator; then shift the multiplicand left and the multiplier right; count++.
- On the edge where count==WIDTH-1:
  - load out with the final accumulator value, two's-complement negated if neg=1, truncated to 2*WIDTH bits;
  - set out_valid=1 and go to DONE.
- DONE: hold out and out_valid. On out_valid & out_ready at an edge, clear out_valid and go to IDLE.
- out keeps the last product after the handshake until the next result is loaded.
- in_valid outside IDLE is ignored and no operand is captured. ina/inb changes after the accept have no effect on the running operation.
- Arithmetic:
  - unsigned range 0..(2^WIDTH-1)^2 always fits.
  - signed: magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held in WIDTH unsigned bits; every signed product fits in 2*WIDTH bits.
  - zero × negative yields 0, never a negative zero pattern.
- aclr asserted in any state, including mid-BUSY, aborts the operation. No partial result appears; outputs return to reset values at once.

## Timing
- Accept at edge T0. BUSY spans edges T0+1 .. T0+WIDTH. out/out_valid update at edge T0+WIDTH, so latency is WIDTH cycles from the accept edge.
- in_ready is combinational from state and aclr. It goes low the cycle after the accept edge and returns high the cycle after the output handshake edge.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH iterations, then the output handshake edge. A new accept can occur on the edge after the DONE→IDLE transition.
- out_valid is never combinationally dependent on out_ready. out_ready held low stalls the block in DONE indefinitely with out stable.
- Release of aclr is synchronised externally; the first accept is possible on the first edge with aclr low.

## Test plan
- WIDTH=8, SIGNED=0: ina=255, inb=255, out_ready=1. Required: out=16'hFE01 with out_valid high exactly 8 cycles after the accept edge; in_ready low for 9 cycles total.
- WIDTH=8, SIGNED=1, back-to-back pairs (-128,-128), (-128,127), (-1,1), (0,-5). Required outputs: 16'h4000, 16'hC080, 16'hFFFF, 16'h0000, each at the same 8-cycle latency.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, and toggle in_valid and ina/inb meanwhile. Required: out stable, in_ready=0, no new operation started; handshake completes on the first edge with out_ready=1.
- Reset mid-op: assert aclr asynchronously at count=3 of 3×5. Required: out=0, out_valid=0, in_ready=0 immediately. After release, 7×6 gives out=16'd42 at normal latency.
- WIDTH=16, SIGNED=0: 16'hFFFF×16'hFFFF. Required: out=32'hFFFE0001 with out_valid 16 cycles after the accept edge.
- Random soak, both SIGNED values, 10k ops with random in_valid/out_ready. Every product matches the reference model, and no accept is taken while in_ready=0.
